// File: rtl/branch_fetch_unit.sv
// Program counter and instruction fetch for the darkraki core.
// Fetches one word at a time, buffers it for decode, and redirects on taken branches.
module branch_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBR_VALID,
  input  logic [31:0] iBR_PC,
  input  logic [31:0] iPCBR,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_ACK,
  input  logic [31:0] iIMEM_RDATA,
  output logic [31:0] oIR,
  output logic [31:0] oIR_PC,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  output logic        oMISALIGN
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc, pc_nx;
  logic [XLEN-1:0]   stale_addr, stale_nx;
  logic [XLEN-1:0]   ir_nx, ir_pc_nx;
  logic              ir_valid_nx, misalign_nx;
  logic [XLEN-1:0]   target;
  logic              taken, redir;

  // Branch resolution: a nonzero offset is taken; only aligned targets redirect
  always_comb begin
    target      = iBR_PC + iPCBR;
    taken       = iBR_VALID && (iPCBR != '0);
    redir       = taken && (target[1:0] == 2'b00);
    misalign_nx = taken && (target[1:0] != 2'b00);
  end

  // Memory request decodes from state; FLUSH replays the address still in flight
  always_comb begin
    oIMEM_REQ  = (state == FETCH) || (state == FLUSH);
    oIMEM_ADDR = (state == FLUSH) ? stale_addr : pc;
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    stale_nx    = stale_addr;
    ir_nx       = oIR;
    ir_pc_nx    = oIR_PC;
    ir_valid_nx = oIR_VALID;
    unique case (state)
      BOOT: begin
        state_nx = FETCH;
        if (redir) pc_nx = target;
      end
      FETCH: begin
        if (iIMEM_ACK && !redir) begin
          ir_nx       = iIMEM_RDATA;
          ir_pc_nx    = pc;
          ir_valid_nx = 1'b1;
          pc_nx       = pc + XLEN'(4);
          state_nx    = HOLD;
        end else if (iIMEM_ACK && redir) begin
          pc_nx = target;
        end else if (redir) begin
          stale_nx = pc;
          pc_nx    = target;
          state_nx = FLUSH;
        end
      end
      HOLD: begin
        if (redir) begin
          ir_valid_nx = 1'b0;
          pc_nx       = target;
          state_nx    = FETCH;
        end else if (iIR_READY) begin
          ir_valid_nx = 1'b0;
          state_nx    = FETCH;
        end
      end
      FLUSH: begin
        if (redir) pc_nx = target;
        if (iIMEM_ACK) state_nx = FETCH;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      stale_addr <= '0;
      oIR        <= '0;
      oIR_PC     <= '0;
      oIR_VALID  <= 1'b0;
      oMISALIGN  <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      stale_addr <= stale_nx;
      oIR        <= ir_nx;
      oIR_PC     <= ir_pc_nx;
      oIR_VALID  <= ir_valid_nx;
      oMISALIGN  <= misalign_nx;
    end
  end

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Directed self-checking bench for branch_fetch_unit.
module tb_branch_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] pcbr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] ir, ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        misalign;

  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_ir, w_ir_pc, w_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  branch_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .iCLK(clk), .iRST(rst), .iBR_VALID(br_valid), .iBR_PC(br_pc), .iPCBR(pcbr),
    .oIMEM_REQ(imem_req), .oIMEM_ADDR(imem_addr), .iIMEM_ACK(imem_ack),
    .iIMEM_RDATA(imem_rdata), .oIR(ir), .oIR_PC(ir_pc), .oIR_VALID(ir_valid),
    .iIR_READY(ir_ready), .oMISALIGN(misalign)
  );

  branch_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .iCLK(clk), .iRST(rst), .iBR_VALID(1'b0), .iBR_PC(32'h0), .iPCBR(32'h0),
    .oIMEM_REQ(w_req), .oIMEM_ADDR(w_addr), .iIMEM_ACK(1'b1),
    .iIMEM_RDATA(w_rdata), .oIR(w_ir), .oIR_PC(w_ir_pc), .oIR_VALID(w_valid),
    .iIR_READY(1'b1), .oMISALIGN(w_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    // reset and boot
    chk("boot_req", 32'(imem_req), 32'h0);
    chk("boot_addr", imem_addr, 32'h100);
    chk("boot_valid", 32'(ir_valid), 32'h0);
    chk("boot_ir", ir, 32'h0);
    chk("boot_ir_pc", ir_pc, 32'h0);
    chk("boot_mis", 32'(misalign), 32'h0);
    chk("wrap_boot_req", 32'(w_req), 32'h0);
    step();
    chk("f0_req", 32'(imem_req), 32'h1);
    chk("f0_addr", imem_addr, 32'h100);
    chk("wrap_f0_addr", w_addr, 32'hFFFF_FFFC);
    step();
    chk("h0_valid", 32'(ir_valid), 32'h1);
    chk("h0_ir_pc", ir_pc, 32'h100);
    chk("h0_ir", ir, 32'hDEAD_0100);
    chk("h0_req", 32'(imem_req), 32'h0);
    chk("wrap_h0_ir_pc", w_ir_pc, 32'hFFFF_FFFC);
    step();
    chk("f1_addr", imem_addr, 32'h104);
    chk("f1_valid", 32'(ir_valid), 32'h0);
    chk("wrap_f1_addr", w_addr, 32'h0);
    chk("wrap_f1_req", 32'(w_req), 32'h1);
    step();
    chk("h1_ir_pc", ir_pc, 32'h104);
    chk("h1_ir", ir, 32'hDEAD_0104);
    step();
    chk("f2_addr", imem_addr, 32'h108);
    step();
    chk("h2_ir_pc", ir_pc, 32'h108);
    // backpressure
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(ir_valid), 32'h1);
      chk("bp_ir", ir, 32'hDEAD_0108);
      chk("bp_req", 32'(imem_req), 32'h0);
      chk("bp_pc", imem_addr, 32'h10C);
    end
    ir_ready = 1'b1;
    step();
    chk("bp_rel_addr", imem_addr, 32'h10C);
    chk("bp_rel_req", 32'(imem_req), 32'h1);
    step();
    chk("h3_ir_pc", ir_pc, 32'h10C);
    // taken backward branch in HOLD
    br_valid = 1'b1; br_pc = 32'h104; pcbr = 32'hFFFF_FFF8;
    step();
    br_valid = 1'b0;
    chk("br_valid_drop", 32'(ir_valid), 32'h0);
    chk("br_addr", imem_addr, 32'h0FC);
    step();
    chk("br_ir_pc", ir_pc, 32'h0FC);
    chk("br_ir", ir, 32'hDEAD_00FC);
    // redirect to 0x200, then wait-stated fetch with mid-wait redirect to 0x400
    br_valid = 1'b1; br_pc = 32'h100; pcbr = 32'h100;
    step();
    br_valid = 1'b0;
    imem_ack = 1'b0;
    chk("ws_addr0", imem_addr, 32'h200);
    step();
    chk("ws_addr1", imem_addr, 32'h200);
    br_valid = 1'b1; br_pc = 32'h300; pcbr = 32'h100;
    step();
    br_valid = 1'b0;
    chk("ws_flush_addr", imem_addr, 32'h200);
    chk("ws_flush_req", 32'(imem_req), 32'h1);
    step();
    chk("ws_flush_addr2", imem_addr, 32'h200);
    imem_ack = 1'b1;
    step();
    chk("ws_new_addr", imem_addr, 32'h400);
    chk("ws_no_present", 32'(ir_valid), 32'h0);
    step();
    chk("ws_ir_pc", ir_pc, 32'h400);
    chk("ws_ir", ir, 32'hDEAD_0400);
    // not-taken branch
    br_valid = 1'b1; br_pc = 32'h400; pcbr = 32'h0;
    step();
    br_valid = 1'b0;
    chk("nt_addr", imem_addr, 32'h404);
    chk("nt_mis", 32'(misalign), 32'h0);
    step();
    chk("nt_ir_pc", ir_pc, 32'h404);
    // misaligned target
    br_valid = 1'b1; br_pc = 32'h100; pcbr = 32'h6;
    step();
    br_valid = 1'b0;
    chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_addr", imem_addr, 32'h408);
    step();
    chk("mis_clear", 32'(misalign), 32'h0);
    chk("mis_ir_pc", ir_pc, 32'h408);
    // async reset while in FLUSH
    step();
    chk("rf_fetch_addr", imem_addr, 32'h40C);
    imem_ack = 1'b0;
    br_valid = 1'b1; br_pc = 32'h400; pcbr = 32'h100;
    step();
    br_valid = 1'b0;
    chk("rf_flush_addr", imem_addr, 32'h40C);
    #3 rst = 1'b1;
    #1;
    chk("rf_req", 32'(imem_req), 32'h0);
    chk("rf_addr", imem_addr, 32'h100);
    chk("rf_valid", 32'(ir_valid), 32'h0);
    chk("rf_ir", ir, 32'h0);
    chk("rf_ir_pc", ir_pc, 32'h0);
    chk("rf_mis", 32'(misalign), 32'h0);
    #1 rst = 1'b0;
    imem_ack = 1'b1;
    step();
    chk("rs_addr", imem_addr, 32'h100);
    chk("rs_req", 32'(imem_req), 32'h1);
    step();
    chk("rs_ir_pc", ir_pc, 32'h100);
    chk("rs_valid", 32'(ir_valid), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
